fp_to_int_converter: RTL

FP_TO_INT_CONVERTER -- requirements
Module: fp_to_int_converter

---
 rtl/fp_to_int_converter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_converter.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int_converter
// Purpose  : Multi-cycle IEEE-754 single -> int32/uint32, round toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_to_int_converter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic        is_unsigned,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        invalid,
  output logic        inexact
);

  localparam logic [1:0] C_IDLE     = 2'd0;
  localparam logic [1:0] C_CLASSIFY = 2'd1;
  localparam logic [1:0] C_SHIFT    = 2'd2;
  localparam logic [1:0] C_DONE     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] op_q, op_d;
  logic        uns_q, uns_d;
  logic [31:0] mag_q, mag_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [31:0] result_q, result_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  logic [7:0]        w_exp;
  logic [22:0]       w_man;
  logic              w_sgn;
  logic signed [9:0] w_e;
  logic [23:0]       w_sig;
  logic [4:0]        w_n;
  logic              w_special;
  logic [31:0]       w_sp_res;
  logic              w_sp_inv;
  logic              w_sp_inx;

  assign w_exp = op_q[30:23];
  assign w_man = op_q[22:0];
  assign w_sgn = op_q[31];
  assign w_e   = $signed({2'b00, w_exp}) - 10'sd127;
  assign w_sig = {(w_exp != 8'd0), w_man};

  // Classification of the captured operand; specials always resolve with N=0.
  always_comb begin
    w_special = 1'b1;
    w_sp_res  = 32'd0;
    w_sp_inv  = 1'b0;
    w_sp_inx  = 1'b0;
    w_n       = 5'd0;
    if (w_exp == 8'hFF) begin
      w_sp_inv = 1'b1;
      if (w_man != 23'd0 || !w_sgn) w_sp_res = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else                          w_sp_res = uns_q ? 32'h0000_0000 : 32'h8000_0000;
    end else if (w_e[9]) begin
      w_sp_inx = |op_q[30:0];
    end else if (!uns_q && w_e >= 10'sd31) begin
      if (op_q == 32'hCF00_0000) begin
        w_sp_res = 32'h8000_0000;
      end else begin
        w_sp_inv = 1'b1;
        w_sp_res = w_sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (uns_q && w_sgn) begin
      w_sp_inv = 1'b1;
    end else if (uns_q && w_e >= 10'sd32) begin
      w_sp_inv = 1'b1;
      w_sp_res = 32'hFFFF_FFFF;
    end else begin
      w_special = 1'b0;
      w_n = (w_e <= 10'sd23) ? (5'd23 - w_e[4:0]) : (w_e[4:0] - 5'd23);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= C_IDLE;
      op_q      <= 32'd0;
      uns_q     <= 1'b0;
      mag_q     <= 32'd0;
      sticky_q  <= 1'b0;
      cnt_q     <= 5'd0;
      left_q    <= 1'b0;
      result_q  <= 32'd0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      uns_q     <= uns_d;
      mag_q     <= mag_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      result_q  <= result_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:     if (start) state_d = C_CLASSIFY;
      C_CLASSIFY: state_d = (w_n != 5'd0) ? C_SHIFT : C_DONE;
      C_SHIFT:    if (cnt_q == 5'd1) state_d = C_DONE;
      C_DONE:     state_d = C_IDLE;
      default:    state_d = C_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    uns_d    = uns_q;
    mag_d    = mag_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          op_d  = operand;
          uns_d = is_unsigned;
        end
      end
      C_CLASSIFY: begin
        mag_d    = {8'd0, w_sig};
        sticky_d = 1'b0;
        cnt_d    = w_n;
        left_d   = (w_e > 10'sd23);
      end
      C_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - 5'd1;
      end
      default: ;
    endcase
  end

  // Result registers load on the edge entering DONE so they are valid with valid_out.
  always_comb begin
    result_d  = result_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;
    if (state_d == C_DONE && state_q != C_DONE) begin
      if (state_q == C_CLASSIFY && w_special) begin
        result_d  = w_sp_res;
        invalid_d = w_sp_inv;
        inexact_d = w_sp_inx;
      end else begin
        result_d  = (w_sgn && !uns_q) ? (32'd0 - mag_d) : mag_d;
        invalid_d = 1'b0;
        inexact_d = sticky_d;
      end
    end
  end

  always_comb begin
    busy      = (state_q != C_IDLE);
    valid_out = (state_q == C_DONE);
    result    = result_q;
    invalid   = invalid_q;
    inexact   = inexact_q;
  end

endmodule
`default_nettype wire
